// File: rtl/sd_cmd_engine.sv
// SD card command-line engine: sends a 48-bit command frame with CRC7, optionally
// receives a 48- or 136-bit response, then clocks out trailing sd_clk periods.
module sd_cmd_engine #(
    parameter int TIMEOUT_CLKS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    input  logic         crc_chk,
    input  logic [7:0]   clk_div,
    output logic         sd_clk,
    output logic         cmd_out,
    output logic         cmd_oe,
    input  logic         cmd_in,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic         crc_err,
    output logic [127:0] resp_data
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND      = 3'd1;
    localparam logic [2:0] WAIT_RESP = 3'd2;
    localparam logic [2:0] RECV      = 3'd3;
    localparam logic [2:0] TRAIL     = 3'd4;
    localparam logic [2:0] FIN       = 3'd5;

    localparam int WAIT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [7:0]        div_cnt_q, div_cnt_d;
    logic              sd_clk_q, sd_clk_d;
    logic              cmd_out_q, cmd_out_d;
    logic              cmd_oe_q, cmd_oe_d;
    logic [46:0]       frame_q, frame_d;
    logic [7:0]        bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]        trail_cnt_q, trail_cnt_d;
    logic [1:0]        resp_type_q, resp_type_d;
    logic              crc_chk_q, crc_chk_d;
    logic [126:0]      rx_sr_q, rx_sr_d;
    logic [127:0]      resp_data_q, resp_data_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              crc_err_q, crc_err_d;

    logic              tick;
    logic              rise;
    logic              fall;
    logic [39:0]       tx_head;
    logic [6:0]        tx_crc;
    logic [127:0]      rx_next;
    logic [6:0]        rx_crc;
    logic [7:0]        rx_last;

    assign tick    = (div_cnt_q == div_q);
    assign rise    = tick & ~sd_clk_q;
    assign fall    = tick & sd_clk_q;
    assign tx_head = {2'b01, cmd_index, cmd_arg};
    assign tx_crc  = crc7_40(tx_head);
    assign rx_next = {rx_sr_q, cmd_in};
    assign rx_crc  = crc7_40(rx_next[47:8]);
    assign rx_last = (resp_type_q == 2'd2) ? 8'd135 : 8'd47;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        div_cnt_d   = div_cnt_q;
        sd_clk_d    = sd_clk_q;
        cmd_out_d   = cmd_out_q;
        cmd_oe_d    = cmd_oe_q;
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        trail_cnt_d = trail_cnt_q;
        resp_type_d = resp_type_q;
        crc_chk_d   = crc_chk_q;
        rx_sr_d     = rx_sr_q;
        resp_data_d = resp_data_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        crc_err_d   = crc_err_q;

        // Divider free-runs in every active state; IDLE and FIN override it below.
        if (tick) begin
            div_cnt_d = 8'd0;
            sd_clk_d  = ~sd_clk_q;
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                sd_clk_d  = 1'b0;
                div_cnt_d = 8'd0;
                // done_q high means the previous transaction ended this very clk.
                if (start && !done_q) begin
                    div_d       = clk_div;
                    resp_type_d = resp_type;
                    crc_chk_d   = crc_chk;
                    frame_d     = {tx_head[38:0], tx_crc, 1'b1};
                    cmd_out_d   = tx_head[39];
                    cmd_oe_d    = 1'b1;
                    bit_cnt_d   = 8'd0;
                    timeout_d   = 1'b0;
                    crc_err_d   = 1'b0;
                    resp_data_d = 128'd0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (fall) begin
                    if (bit_cnt_q == 8'd47) begin
                        cmd_oe_d    = 1'b0;
                        cmd_out_d   = 1'b1;
                        wait_cnt_d  = '0;
                        trail_cnt_d = 3'd0;
                        state_d     = (resp_type_q == 2'd1 || resp_type_q == 2'd2) ? WAIT_RESP : TRAIL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                        cmd_out_d = frame_q[46];
                        frame_d   = {frame_q[45:0], 1'b0};
                    end
                end
            end
            WAIT_RESP: begin
                if (rise) begin
                    if (!cmd_in) begin
                        rx_sr_d   = '0;
                        bit_cnt_d = 8'd1;
                        state_d   = RECV;
                    end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CLKS - 1)) begin
                        timeout_d   = 1'b1;
                        trail_cnt_d = 3'd0;
                        state_d     = TRAIL;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            RECV: begin
                if (rise) begin
                    rx_sr_d   = rx_next[126:0];
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == rx_last) begin
                        if (resp_type_q == 2'd2) begin
                            resp_data_d = rx_next;
                        end else begin
                            resp_data_d = {90'd0, rx_next[45:8]};
                            crc_err_d   = crc_chk_q && (rx_crc != rx_next[7:1]);
                        end
                        trail_cnt_d = 3'd0;
                        state_d     = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (fall) begin
                    if (trail_cnt_q == 3'd7) begin
                        state_d = FIN;
                    end else begin
                        trail_cnt_d = trail_cnt_q + 3'd1;
                    end
                end
            end
            FIN: begin
                sd_clk_d  = 1'b0;
                div_cnt_d = 8'd0;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= 8'd0;
            div_cnt_q   <= 8'd0;
            sd_clk_q    <= 1'b0;
            cmd_out_q   <= 1'b1;
            cmd_oe_q    <= 1'b0;
            frame_q     <= '0;
            bit_cnt_q   <= 8'd0;
            wait_cnt_q  <= '0;
            trail_cnt_q <= 3'd0;
            resp_type_q <= 2'd0;
            crc_chk_q   <= 1'b0;
            rx_sr_q     <= '0;
            resp_data_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            div_cnt_q   <= div_cnt_d;
            sd_clk_q    <= sd_clk_d;
            cmd_out_q   <= cmd_out_d;
            cmd_oe_q    <= cmd_oe_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            trail_cnt_q <= trail_cnt_d;
            resp_type_q <= resp_type_d;
            crc_chk_q   <= crc_chk_d;
            rx_sr_q     <= rx_sr_d;
            resp_data_q <= resp_data_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            crc_err_q   <= crc_err_d;
        end
    end

    assign sd_clk      = sd_clk_q;
    assign cmd_out     = cmd_out_q;
    assign cmd_oe      = cmd_oe_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign crc_err     = crc_err_q;
    assign resp_data   = resp_data_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: the driver queues expected frames/results,
// monitors decode cmd_out and check each done pulse against the queues.
module tb_sd_cmd_engine;

    typedef struct packed {
        logic         to;
        logic         ce;
        logic [127:0] data;
        int           lat;
    } res_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [5:0]   cmd_index = 6'd0;
    logic [31:0]  cmd_arg = 32'd0;
    logic [1:0]   resp_type = 2'd0;
    logic         crc_chk = 1'b0;
    logic [7:0]   clk_div = 8'd0;
    logic         sd_clk;
    logic         cmd_out;
    logic         cmd_oe;
    logic         cmd_in = 1'b1;
    logic         busy;
    logic         done;
    logic         timeout_err;
    logic         crc_err;
    logic [127:0] resp_data;

    int checks = 0;
    int failures = 0;
    int txn = 0;

    logic [47:0] exp_frame[$];
    res_t        exp_res[$];

    logic         card_en = 1'b0;
    logic [135:0] card_bits = '0;
    int           card_len = 48;

    sd_cmd_engine #(.TIMEOUT_CLKS(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .resp_type   (resp_type),
        .crc_chk     (crc_chk),
        .clk_div     (clk_div),
        .sd_clk      (sd_clk),
        .cmd_out     (cmd_out),
        .cmd_oe      (cmd_oe),
        .cmd_in      (cmd_in),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .crc_err     (crc_err),
        .resp_data   (resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Card model: answers after two sd_clk falls, changing cmd_in on falls.
    initial begin
        forever begin
            @(negedge cmd_oe);
            if (card_en) begin
                repeat (2) @(negedge sd_clk);
                for (int i = card_len - 1; i >= 0; i--) begin
                    cmd_in = card_bits[i];
                    @(negedge sd_clk);
                end
                cmd_in = 1'b1;
            end
        end
    end

    // Monitor: frame decode on sd_clk rises, result check on done.
    initial begin
        logic [47:0] fshift;
        int          fcnt;
        int          lat_cnt;
        logic        prev_sclk;
        logic        prev_done;
        logic [47:0] ef;
        res_t        r;
        fshift = '0;
        fcnt = 0;
        lat_cnt = 0;
        prev_sclk = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy) begin
                fcnt = 0;
            end else if (sd_clk && !prev_sclk && cmd_oe) begin
                fshift = {fshift[46:0], cmd_out};
                fcnt++;
                if (fcnt == 48) begin
                    fcnt = 0;
                    if (exp_frame.size() == 0) begin
                        chk("unexpected_frame", {80'd0, fshift}, 128'd0);
                    end else begin
                        ef = exp_frame.pop_front();
                        chk("frame", {80'd0, fshift}, {80'd0, ef});
                    end
                end
            end
            prev_sclk = sd_clk;

            if (done) begin
                txn++;
                $display("txn %0d: timeout_err=%0b crc_err=%0b resp_data=%032h latency=%0d",
                         txn, timeout_err, crc_err, resp_data, lat_cnt);
                chk("done_single_pulse", {127'd0, prev_done}, 128'd0);
                chk("busy_at_done", {127'd0, busy}, 128'd0);
                if (exp_res.size() == 0) begin
                    chk("unexpected_done", 128'd1, 128'd0);
                end else begin
                    r = exp_res.pop_front();
                    chk("timeout_err", {127'd0, timeout_err}, {127'd0, r.to});
                    chk("crc_err", {127'd0, crc_err}, {127'd0, r.ce});
                    chk("resp_data", resp_data, r.data);
                    if (r.lat >= 0) begin
                        chk("done_latency", 128'(lat_cnt), 128'(r.lat));
                    end
                end
                lat_cnt = 0;
            end else if (busy) begin
                lat_cnt++;
            end else begin
                lat_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic wait_idle(input bit noisy);
        int i;
        for (i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (noisy) begin
                start     = ((i % 7) == 3);
                cmd_index = 6'($urandom_range(0, 63));
                cmd_arg   = $urandom;
            end
        end
        start = 1'b0;
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL wait_idle: busy still %0b after %0d clks, required 0", busy, i);
        end
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                           input logic cc, input logic [7:0] div, input logic cen,
                           input logic [135:0] cbits, input int clen, input logic [47:0] ef,
                           input logic eto, input logic ece, input logic [127:0] edata,
                           input int elat, input bit noisy);
        res_t r;
        card_en   = cen;
        card_bits = cbits;
        card_len  = clen;
        r.to = eto;
        r.ce = ece;
        r.data = edata;
        r.lat = elat;
        exp_frame.push_back(ef);
        exp_res.push_back(r);
        @(negedge clk);
        cmd_index = idx;
        cmd_arg   = arg;
        resp_type = rt;
        crc_chk   = cc;
        clk_div   = div;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {127'd0, busy}, 128'd1);
        wait_idle(noisy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sd_clk", {127'd0, sd_clk}, 128'd0);
        chk("rst_cmd_out", {127'd0, cmd_out}, 128'd1);
        chk("rst_cmd_oe", {127'd0, cmd_oe}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_timeout", {127'd0, timeout_err}, 128'd0);
        chk("rst_crc_err", {127'd0, crc_err}, 128'd0);
        chk("rst_resp_data", resp_data, 128'd0);

        // CMD0, no response: 56 sd_clk periods of 2 clks, plus the FIN clk.
        run_cmd(6'd0, 32'd0, 2'd0, 1'b0, 8'd0, 1'b0, '0, 48,
                48'h400000000095, 1'b0, 1'b0, 128'd0, 113, 1'b0);

        // CMD8 with a good R7 response.
        run_cmd(6'd8, 32'h000001AA, 2'd1, 1'b1, 8'd1, 1'b1, {88'd0, 48'h08000001AA13}, 48,
                48'h48000001AA87, 1'b0, 1'b0, {88'd0, 40'h08000001AA}, -1, 1'b0);

        // CMD8 with a corrupted CRC byte.
        run_cmd(6'd8, 32'h000001AA, 2'd1, 1'b1, 8'd1, 1'b1, {88'd0, 48'h08000001AA15}, 48,
                48'h48000001AA87, 1'b0, 1'b1, {88'd0, 40'h08000001AA}, -1, 1'b0);

        // CMD55, card silent: 48 periods + 64 rises + 8 falls at 2 clks/period.
        run_cmd(6'd55, 32'd0, 2'd1, 1'b1, 8'd0, 1'b0, '0, 48,
                48'h770000000065, 1'b1, 1'b0, 128'd0, 239, 1'b0);

        // resp_type 3 behaves as no response; clk_div 1 gives 4 clks per period.
        run_cmd(6'd0, 32'd0, 2'd3, 1'b0, 8'd1, 1'b0, '0, 48,
                48'h400000000095, 1'b0, 1'b0, 128'd0, 225, 1'b0);

        // CMD2 with a 136-bit response and start toggling while busy.
        run_cmd(6'd2, 32'd0, 2'd2, 1'b1, 8'd2, 1'b1, {8'h3F, {16{8'hA5}}}, 136,
                48'h42000000004D, 1'b0, 1'b0, {16{8'hA5}}, -1, 1'b1);

        // Start raised only in the done clk must be ignored.
        cmd_index = 6'd0;
        cmd_arg   = 32'd0;
        resp_type = 2'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_on_done_ignored", {127'd0, busy}, 128'd0);
        @(negedge clk);
        chk("start_on_done_still_idle", {127'd0, busy}, 128'd0);

        // Abort mid-SEND with reset (start held high too), then a clean frame.
        card_en = 1'b0;
        @(negedge clk);
        cmd_index = 6'd8;
        cmd_arg   = 32'h000001AA;
        resp_type = 2'd1;
        clk_div   = 8'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_send_oe", {127'd0, cmd_oe}, 128'd1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("abort_cmd_oe", {127'd0, cmd_oe}, 128'd0);
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_sd_clk", {127'd0, sd_clk}, 128'd0);
        chk("abort_cmd_out", {127'd0, cmd_out}, 128'd1);
        repeat (3) @(negedge clk);

        run_cmd(6'd0, 32'd0, 2'd0, 1'b0, 8'd3, 1'b0, '0, 48,
                48'h400000000095, 1'b0, 1'b0, 128'd0, 449, 1'b0);

        repeat (10) @(negedge clk);
        chk("frames_outstanding", 128'(exp_frame.size()), 128'd0);
        chk("results_outstanding", 128'(exp_res.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
